// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide on magnitudes,
// one bit per cycle, with sign correction applied as the final result is registered.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            kill,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            ready,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CW = $clog2(XLEN);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e            state_q, state_d;
  logic [2:0]        f3_q, f3_d;
  logic [XLEN-1:0]   b_q, b_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic              neg_rem_q, neg_rem_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Operand decode at launch
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;
  logic            is_div, div_zero, div_ovf;
  logic [XLEN-1:0] special_res;

  always_comb begin
    a_signed = (funct3 != 3'b011) && (funct3 != 3'b101) && (funct3 != 3'b111);
    b_signed = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b100) ||
               (funct3 == 3'b110);
    a_neg    = a_signed & op_a[XLEN-1];
    b_neg    = b_signed & op_b[XLEN-1];
    a_mag    = a_neg ? -op_a : op_a;
    b_mag    = b_neg ? -op_b : op_b;
    is_div   = funct3[2];
    div_zero = is_div && (op_b == '0);
    div_ovf  = is_div && !funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    if (div_zero) begin
      special_res = funct3[1] ? op_a : '1;
    end else begin
      special_res = funct3[1] ? '0 : op_a;
    end
  end

  // One iteration step; acc holds {hi, lo} for multiply and {remainder, quotient} for divide
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_nxt;
  logic [XLEN:0]     rem_sh, diff;
  logic [2*XLEN-1:0] div_nxt;
  logic [2*XLEN-1:0] iter_nxt;

  always_comb begin
    mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, b_q} : '0);
    mul_nxt  = {mul_sum, acc_q[XLEN-1:1]};
    rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    diff     = rem_sh - {1'b0, b_q};
    // Borrow out means the trial subtraction failed: keep the shifted remainder
    if (diff[XLEN]) begin
      div_nxt = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      div_nxt = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end
    iter_nxt = f3_q[2] ? div_nxt : mul_nxt;
  end

  logic [2*XLEN-1:0] prod_sc;
  logic [XLEN-1:0]   quo, rem, final_res;

  always_comb begin
    prod_sc = neg_q ? -iter_nxt : iter_nxt;
    quo     = iter_nxt[XLEN-1:0];
    rem     = iter_nxt[2*XLEN-1:XLEN];
    case (f3_q)
      3'b000:                 final_res = prod_sc[XLEN-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod_sc[2*XLEN-1:XLEN];
      3'b100, 3'b101:         final_res = neg_q ? -quo : quo;
      default:                final_res = neg_rem_q ? -rem : rem;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    f3_d      = f3_q;
    b_d       = b_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    if (kill) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            f3_d      = funct3;
            b_d       = b_mag;
            acc_d     = {{XLEN{1'b0}}, a_mag};
            cnt_d     = '0;
            neg_d     = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            if (div_zero || div_ovf) begin
              result_d = special_res;
              state_d  = StDone;
            end else begin
              state_d = StBusy;
            end
          end
        end
        StBusy: begin
          acc_d = iter_nxt;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(XLEN - 1)) begin
            result_d = final_res;
            state_d  = StDone;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StIdle;
      f3_q      <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      f3_q      <= f3_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

  assign busy   = (state_q == StBusy);
  assign ready  = (state_q == StDone);
  assign result = result_q;

endmodule
